mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the multi-cycle core's single unified instruction/data memory between the core's memory interface (port 0) and an external loader/DMA port (port 1). It accepts one transaction at a time and registers the winning request into the memory port. It waits a variable number of cycles for the memory to complete, then returns a one-cycle acknowledge with read data, or a timeout error, to the owning requester. Round-robin priority prevents either side from starving the other. The block sits between the core's address mux and the memory.

## Interface
- TIMEOUT, 16: maximum ISSUE cycles waited for mem_ready before aborting; legal range 2..255.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req, m1_req  input  1 each  request valid; held high with stable fields until the matching ack.
- m0_we, m1_we  input  1 each  1 = write, 0 = read.
- m0_addr, m1_addr  input  32 each  word address.
- m0_wdata, m1_wdata  input  32 each  write data.
- m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
- m0_err, m1_err  output  1 each  valid with ack; 1 = timeout abort.
- m0_rdata, m1_rdata  output  32 each  read data; valid with ack.
- mem_valid  output  1  transaction presented to memory.
- mem_we  output  1  registered write enable.
- mem_addr  output  32  registered address.
- mem_wdata  output  32  registered write data.
- mem_ready  input  1  memory completes the presented transaction this cycle.
- mem_rdata  input  32  read data; valid when mem_ready=1.
- busy  output  1  state != IDLE.
- owner  output  1  port currently granted; also the last granted port when idle.

## Operation
- States: IDLE, ISSUE, RESP. Reset state is IDLE.
- Reset values:
  - All acks, errs and mem_valid are 0.
  - rdata, mem_addr, mem_wdata and mem_we are 0.
  - owner is 0.
  - Priority pointer favours port 0.
  - Timeout counter is 0.
- IDLE:
  - If no request is pending, remain in IDLE.
  - If exactly one port requests, grant that port.
  - If both ports request, grant the port named by the priority pointer.
  - On grant: capture we, addr and wdata into the mem_* registers; set owner; clear the counter; go to ISSUE.
  - The pointer then moves to the other port, giving strict alternation under continuous contention.
- ISSUE:
  - mem_valid is 1.
  - On mem_ready=1: capture mem_rdata (writes return 0 on rdata) and go to RESP with err=0.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT-1 with mem_ready still 0: go to RESP with err=1 and rdata=0.
  - mem_valid drops on entry to RESP in both cases.
- RESP:
  - The owner's ack is 1 for exactly this cycle, with err and rdata valid. The other port's ack, err and rdata stay 0.
  - Always return to IDLE. No request is sampled in RESP.
- Requester rule:
  - A port must not change its request fields while req is high and no ack has been received.
  - A port may deassert req, or present a new transaction, starting in the cycle after its ack.
- Behaviour of the non-owner port:
  - req rising or falling on the non-owner port during ISSUE/RESP has no effect.
  - That port is evaluated at the next IDLE.
- Asynchronous reset mid-transaction immediately forces IDLE and deasserts mem_valid and all acks. No ack is produced for the aborted transaction.
- A mem_ready pulse arriving in IDLE or RESP is ignored.

## Timing
- Minimum transaction is 3 cycles, with mem_ready=1 in the first ISSUE cycle:
  - cycle 0: IDLE; req is sampled.
  - cycle 1: ISSUE; mem_valid=1.
  - cycle 2: RESP; ack=1.
  - cycle 3: IDLE; next arbitration.
- Each wait cycle of memory (mem_ready low) adds one cycle.
- Timeout:
  - ISSUE lasts exactly TIMEOUT cycles.
  - ack with err arrives TIMEOUT+1 cycles after the grant edge.
- Back-to-back throughput is one transaction per 3 cycles under zero-wait memory.
- All outputs are registered, with no combinational path from any input to any output.

## Test plan
- Single read, port 0:
  - Stimulus: m0 reads addr 0x10; mem_ready=1 in the first ISSUE cycle with mem_rdata=0xDEADBEEF.
  - Required: mem_valid high for exactly 1 cycle; m0_ack with rdata 0xDEADBEEF, err=0, at cycle 2; m1_ack stays 0.
- Contention:
  - Stimulus: m0 and m1 both request continuously, with 4 transactions each.
  - Required: grant order 0,1,0,1,0,1,0,1; each ack goes to the correct port with its own addr visible on mem_addr.
- Wait states:
  - Stimulus: m1 writes 0xCAFEF00D to 0x40; mem_ready is delayed 3 cycles.
  - Required: mem_valid high for 4 cycles with mem_we=1 and mem_wdata=0xCAFEF00D; m1_ack in the 6th cycle.
- Timeout:
  - Stimulus: TIMEOUT=16; mem_ready never asserts.
  - Required: mem_valid high for exactly 16 cycles; ack with err=1 and rdata=0; the next queued request is then served normally.
- Reset mid-ISSUE:
  - Stimulus: reset is pulled low during a wait state.
  - Required: mem_valid and busy drop asynchronously, no ack occurs, owner=0; after release, m0 has priority over a simultaneous m1 request.
- Stray mem_ready:
  - Stimulus: mem_ready pulses while in IDLE, and while in RESP.
  - Required: no ack is produced and no state change occurs.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, memory and status signals of the two-port memory arbiter
// slave is the arbiter's view; master is the surrounding core/loader/memory view.
interface mem_arbiter_if;
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_ack;
   logic        m0_err;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_ack;
   logic        m1_err;
   logic [31:0] m1_rdata;

   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   logic        busy;
   logic        owner;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_ready, mem_rdata,
      output m0_ack, m0_err, m0_rdata,
      output m1_ack, m1_err, m1_rdata,
      output mem_valid, mem_we, mem_addr, mem_wdata,
      output busy, owner
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_ready, mem_rdata,
      input  m0_ack, m0_err, m0_rdata,
      input  m1_ack, m1_err, m1_rdata,
      input  mem_valid, mem_we, mem_addr, mem_wdata,
      input  busy, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter for the shared unified memory
// One transaction in flight: IDLE grants, ISSUE waits for mem_ready or timeout, RESP acks.
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic        owner_q, owner_d;
   logic        prio_q, prio_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_valid_q, mem_valid_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        busy_q, busy_d;
   logic [1:0]  ack_q, ack_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic        grant;
   logic        done;
   logic        timed_out;
   logic [31:0] resp_data;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      prio_d      = prio_q;
      cnt_d       = cnt_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      rdata0_d    = 32'h0;
      rdata1_d    = 32'h0;
      grant       = 1'b0;
      done        = 1'b0;
      timed_out   = 1'b0;
      resp_data   = 32'h0;

      case (state_q)
         IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               // Contention goes to the pointer; a lone requester wins outright.
               grant       = (bus.m0_req && bus.m1_req) ? prio_q : bus.m1_req;
               owner_d     = grant;
               prio_d      = ~grant;
               mem_we_d    = grant ? bus.m1_we    : bus.m0_we;
               mem_addr_d  = grant ? bus.m1_addr  : bus.m0_addr;
               mem_wdata_d = grant ? bus.m1_wdata : bus.m0_wdata;
               cnt_d       = 8'h0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ready) begin
               done      = 1'b1;
               resp_data = mem_we_q ? 32'h0 : bus.mem_rdata;
            end else if (cnt_q == CNT_LAST) begin
               done      = 1'b1;
               timed_out = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'h1;
            end
            if (done) begin
               state_d         = RESP;
               ack_d[owner_q]  = 1'b1;
               err_d[owner_q]  = timed_out;
               if (owner_q) begin
                  rdata1_d = resp_data;
               end else begin
                  rdata0_d = resp_data;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      mem_valid_d = (state_d == ISSUE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         prio_q      <= 1'b0;
         cnt_q       <= 8'h0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         busy_q      <= 1'b0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         rdata0_q    <= 32'h0;
         rdata1_q    <= 32'h0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         mem_valid_q <= mem_valid_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign bus.m0_ack    = ack_q[0];
   assign bus.m1_ack    = ack_q[1];
   assign bus.m0_err    = err_q[0];
   assign bus.m1_err    = err_q[1];
   assign bus.m0_rdata  = rdata0_q;
   assign bus.m1_rdata  = rdata1_q;
   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          waitc;
      int          vlen;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   grant_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   ack_total = 0;
   logic stray = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory model: completes after waitc ISSUE cycles (never when waitc < 0).
   initial begin : mem_model
      int k;
      int w;
      k = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.mem_valid && ((bus.owner ? q1.size() : q0.size()) > 0)) begin
            w = bus.owner ? q1[0].waitc : q0[0].waitc;
            bus.mem_ready = (k == w);
            bus.mem_rdata = (k == w) ? rd_of(bus.mem_addr) : $urandom;
            k++;
         end else begin
            k = 0;
            bus.mem_ready = stray;
            bus.mem_rdata = $urandom;
         end
      end
   end

   initial begin : monitor
      logic pv;
      int   vcnt;
      int   p;
      int   qs;
      exp_t e;
      pv = 1'b0;
      vcnt = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_valid) begin
            if (!pv) begin
               vcnt = 0;
               if (grant_q.size() > 0) begin
                  p = grant_q.pop_front();
                  chk("grant_order", 32'(bus.owner), 32'(p));
               end
               p  = int'(bus.owner);
               qs = p ? q1.size() : q0.size();
               chk("pending_at_grant", 32'(qs > 0), 32'd1);
               if (qs > 0) begin
                  e = p ? q1[0] : q0[0];
                  chk("mem_addr", bus.mem_addr, e.addr);
                  chk("mem_we", 32'(bus.mem_we), 32'(e.we));
                  chk("mem_wdata", bus.mem_wdata, e.wdata);
               end
            end
            vcnt++;
         end
         pv = bus.mem_valid;
         if (bus.m0_ack || bus.m1_ack) begin
            ack_total++;
            chk("single_ack", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
            p  = int'(bus.m1_ack);
            qs = p ? q1.size() : q0.size();
            chk("pending_at_ack", 32'(qs > 0), 32'd1);
            if (qs > 0) begin
               e = p ? q1.pop_front() : q0.pop_front();
               chk("rdata", p ? bus.m1_rdata : bus.m0_rdata, e.rdata);
               chk("err", 32'(p ? bus.m1_err : bus.m0_err), 32'(e.err));
               chk("valid_cycles", 32'(vcnt), 32'(e.vlen));
               chk("other_rdata", p ? bus.m0_rdata : bus.m1_rdata, 32'h0);
               chk("other_err", 32'(p ? bus.m0_err : bus.m1_err), 32'd0);
               chk("owner_at_ack", 32'(bus.owner), 32'(p));
            end
         end
      end
   end

   task automatic xact(input int p, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input int waitc, input int exp_lat);
      exp_t e;
      int   t0;
      logic got;
      e.addr  = a;
      e.we    = w;
      e.wdata = d;
      e.waitc = waitc;
      e.err   = (waitc < 0);
      e.rdata = (w || waitc < 0) ? 32'h0 : rd_of(a);
      e.vlen  = (waitc < 0) ? TIMEOUT : waitc + 1;
      if (p == 0) begin
         q0.push_back(e);
         bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_req = 1'b1;
      end else begin
         q1.push_back(e);
         bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_req = 1'b1;
      end
      t0  = cyc;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = (p == 0) ? bus.m0_ack : bus.m1_ack;
      end
      chk("ack_seen", 32'(got), 32'd1);
      if (got && exp_lat >= 0) chk("ack_latency", 32'(cyc - t0), 32'(exp_lat));
      @(posedge clk);
      #1;
      if (p == 0) bus.m0_req = 1'b0;
      else        bus.m1_req = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int   base_acks;
      exp_t e;
      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
      chk("rst_err", {30'h0, bus.m1_err, bus.m0_err}, 32'h0);
      chk("rst_rdata0", bus.m0_rdata, 32'h0);
      chk("rst_rdata1", bus.m1_rdata, 32'h0);
      chk("rst_mem", {29'h0, bus.mem_valid, bus.mem_we, bus.busy}, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Continuous contention: strict alternation starting with port 0.
      for (int i = 0; i < 8; i++) grant_q.push_back(i % 2);
      fork
         begin
            for (int i = 0; i < 4; i++)
               xact(0, 32'h100 + 32'(i), logic'(i % 2), 32'hA000 + 32'(i), 0, -1);
         end
         begin
            for (int j = 0; j < 4; j++)
               xact(1, 32'h200 + 32'(j), 1'b0, 32'hB000 + 32'(j), 0, -1);
         end
      join
      chk("grant_q_drained", 32'(grant_q.size()), 32'd0);

      xact(0, 32'h10, 1'b0, 32'h0, 0, 2);
      xact(1, 32'h40, 1'b1, 32'hCAFEF00D, 3, 5);

      // Timeout on port 0 while port 1 queues behind it.
      fork
         xact(0, 32'h50, 1'b0, 32'h0, -1, TIMEOUT + 1);
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("busy_during_timeout", 32'(bus.busy), 32'd1);
            xact(1, 32'h60, 1'b0, 32'h0, 0, -1);
         end
      join

      // Stray mem_ready in IDLE, then in IDLE/RESP around a transaction.
      base_acks = ack_total;
      stray = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stray_idle_busy", 32'(bus.busy), 32'd0);
      end
      chk("stray_idle_no_ack", 32'(ack_total), 32'(base_acks));
      xact(0, 32'h20, 1'b0, 32'h0, 2, 4);
      @(negedge clk);
      chk("stray_after_resp_busy", 32'(bus.busy), 32'd0);
      chk("stray_acks", 32'(ack_total), 32'(base_acks + 1));
      stray = 1'b0;
      @(posedge clk);
      #1;

      // Asynchronous reset while port 0 waits on memory.
      e.addr = 32'h70; e.we = 1'b0; e.wdata = 32'h0; e.rdata = 32'h0;
      e.err = 1'b1; e.waitc = -1; e.vlen = TIMEOUT;
      q0.push_back(e);
      bus.m0_we = 1'b0; bus.m0_addr = 32'h70; bus.m0_req = 1'b1;
      base_acks = ack_total;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_rst_valid", 32'(bus.mem_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("rst_async_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_async_busy", 32'(bus.busy), 32'd0);
      chk("rst_async_owner", 32'(bus.owner), 32'd0);
      chk("rst_async_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
      bus.m0_req = 1'b0;
      q0.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      grant_q.push_back(0);
      grant_q.push_back(1);
      fork
         xact(0, 32'h300, 1'b0, 32'h0, 0, 2);
         xact(1, 32'h304, 1'b1, 32'h1234, 0, -1);
      join
      chk("rst_acks", 32'(ack_total), 32'(base_acks + 2));

      repeat (3) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("grant_q_final", 32'(grant_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
